// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM arbiter: sequencer select codes, FSM states and
// the ceiling on owed refreshes.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    SelPort0   = 2'b00,
    SelPort1   = 2'b01,
    SelRefresh = 2'b10,
    SelNone    = 2'b11
  } seq_sel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StBusy  = 2'b10
  } arb_state_e;

  localparam logic [3:0] PendingMax = 4'd8;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer and saturating count of refreshes owed.
// Held at reload / zero until SDRAM initialisation completes.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 780
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_done_i,
  input  logic       service_i,
  output logic [3:0] pending_o
);

  localparam int unsigned TimerW = ($clog2(REFRESH_PERIOD) > 0) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [TimerW-1:0] Reload = TimerW'(REFRESH_PERIOD - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        pending_q, pending_d;
  logic              tick;

  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    tick      = 1'b0;
    if (!init_done_i) begin
      timer_d   = Reload;
      pending_d = '0;
    end else begin
      if (timer_q == '0) begin
        timer_d = Reload;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q - 1'b1;
      end
      // A tick landing on a serviced refresh cancels out.
      if (tick && !service_i) begin
        if (pending_q != PendingMax) pending_d = pending_q + 4'd1;
      end else if (!tick && service_i && (pending_q != '0)) begin
        pending_d = pending_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q   <= Reload;
      pending_q <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM sequencer arbiter with refresh scheduling.
// Define SDRAM_ARB_ROUND_ROBIN_EN to alternate between simultaneous requesters.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned URGENT_LEVEL   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INIT_DONE,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       SEQ_DONE,
  output logic       GNT0,
  output logic       GNT1,
  output logic       SEQ_START,
  output logic [1:0] SEQ_SEL,
  output logic [3:0] REF_PENDING
);

  localparam logic [3:0] UrgentLvl = 4'(URGENT_LEVEL);

  arb_state_e state_q, state_d;
  seq_sel_e   sel_q, sel_d, pick, port_pick;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       start_q, start_d;
  logic       last1_q, last1_d;
  logic       armed_q, armed_d;
  logic       service;

  assign service = start_q && (sel_q == SelRefresh);

  sdram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .init_done_i(INIT_DONE),
    .service_i  (service),
    .pending_o  (REF_PENDING)
  );

  always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    if (REQ0 && REQ1) port_pick = last1_q ? SelPort0 : SelPort1;
    else              port_pick = REQ0 ? SelPort0 : SelPort1;
`else
    port_pick = REQ0 ? SelPort0 : SelPort1;
`endif
    pick = SelNone;
    if (REF_PENDING >= UrgentLvl)    pick = SelRefresh;
    else if (REQ0 || REQ1)           pick = port_pick;
    else if (REF_PENDING != '0)      pick = SelRefresh;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    last1_d = last1_q;
    start_d = 1'b0;
    // Blocks selection on the first edge after reset release.
    armed_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (INIT_DONE && armed_q && (pick != SelNone)) begin
          state_d = StStart;
          start_d = 1'b1;
          sel_d   = pick;
          gnt0_d  = (pick == SelPort0);
          gnt1_d  = (pick == SelPort1);
          if (pick == SelPort0)      last1_d = 1'b0;
          else if (pick == SelPort1) last1_d = 1'b1;
        end
      end
      StStart: state_d = StBusy;
      StBusy: begin
        if (SEQ_DONE) begin
          state_d = StIdle;
          sel_d   = SelNone;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = SelNone;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      sel_q   <= SelNone;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      start_q <= 1'b0;
      last1_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      start_q <= start_d;
      last1_q <= last1_d;
      armed_q <= armed_d;
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign SEQ_START = start_q;
  assign SEQ_SEL   = sel_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (REFRESH_PERIOD=20, URGENT_LEVEL=4).
module tb_sdram_arbiter;

  logic       CLK = 1'b0;
  logic       RESET, INIT_DONE, REQ0, REQ1, SEQ_DONE;
  logic       GNT0, GNT1, SEQ_START;
  logic [1:0] SEQ_SEL;
  logic [3:0] REF_PENDING;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  sdram_arbiter #(
    .REFRESH_PERIOD(20),
    .URGENT_LEVEL  (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .INIT_DONE  (INIT_DONE),
    .REQ0       (REQ0),
    .REQ1       (REQ1),
    .SEQ_DONE   (SEQ_DONE),
    .GNT0       (GNT0),
    .GNT1       (GNT1),
    .SEQ_START  (SEQ_START),
    .SEQ_SEL    (SEQ_SEL),
    .REF_PENDING(REF_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic init);
    RESET    = 1'b1;
    REQ0     = 1'b0;
    REQ1     = 1'b0;
    SEQ_DONE = 1'b0;
    tick();
    RESET     = 1'b0;
    INIT_DONE = init;
    cyc       = 0;
  endtask

  // Grant exclusivity watched on every falling edge.
  always @(negedge CLK) begin
    if (mon_en)
      check_eq("excl", 32'((GNT0 && GNT1) || ((GNT0 || GNT1) && SEQ_SEL == 2'b10)), 32'd0);
  end

  initial begin
    int         bad;
    int         waited;
    logic [3:0] exp_seq;

    RESET = 1'b0; INIT_DONE = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; SEQ_DONE = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check_eq("rst_gnt0", GNT0, 0);
    check_eq("rst_gnt1", GNT1, 0);
    check_eq("rst_start", SEQ_START, 0);
    check_eq("rst_sel", SEQ_SEL, 3);
    check_eq("rst_pend", REF_PENDING, 0);
    mon_en = 1'b1;

    // Uninitialised SDRAM: nothing may be granted, no refresh owed.
    do_reset(1'b0);
    REQ0 = 1'b1;
    bad  = 0;
    repeat (2000) begin
      tick();
      if (GNT0 || GNT1 || SEQ_START || REF_PENDING != 4'd0) bad++;
    end
    check_eq("init_hold_bad", bad, 0);
    check_eq("init_pend", REF_PENDING, 0);

    // Single CPU transaction.
    do_reset(1'b1);
    REQ0 = 1'b1;
    tick();
    check_eq("first_edge_gnt0", GNT0, 0);
    check_eq("first_edge_start", SEQ_START, 0);
    tick();
    check_eq("start_gnt0", GNT0, 1);
    check_eq("start_pulse", SEQ_START, 1);
    check_eq("start_sel", SEQ_SEL, 0);
    REQ0 = 1'b0;
    tick();
    check_eq("busy_start_low", SEQ_START, 0);
    check_eq("busy_gnt0_withdrawn", GNT0, 1);
    repeat (3) tick();
    check_eq("busy_gnt0_hold", GNT0, 1);
    SEQ_DONE = 1'b1;
    tick();
    SEQ_DONE = 1'b0;
    check_eq("done_gnt0", GNT0, 0);
    check_eq("done_sel", SEQ_SEL, 3);
    tick();
    check_eq("idle_no_start", SEQ_START, 0);

    // SEQ_DONE during START is ignored; then reset mid-BUSY.
    REQ1 = 1'b1;
    tick();
    check_eq("p1_gnt1", GNT1, 1);
    check_eq("p1_sel", SEQ_SEL, 1);
    check_eq("p1_start", SEQ_START, 1);
    SEQ_DONE = 1'b1;
    REQ1     = 1'b0;
    tick();
    SEQ_DONE = 1'b0;
    check_eq("done_in_start_ignored", GNT1, 1);
    tick();
    check_eq("p1_busy_gnt1", GNT1, 1);
    #3 RESET = 1'b1;
    #1;
    check_eq("async_rst_gnt1", GNT1, 0);
    check_eq("async_rst_sel", SEQ_SEL, 3);
    check_eq("async_rst_pend", REF_PENDING, 0);
    RESET = 1'b0;
    bad   = 0;
    repeat (3) begin
      tick();
      if (SEQ_START) bad++;
    end
    check_eq("post_rst_no_start", bad, 0);

    // Simultaneous requesters, four grants.
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    do_reset(1'b1);
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (!SEQ_START && waited < 10) begin
        tick();
        waited++;
      end
      check_eq($sformatf("arb_start%0d", g), SEQ_START, 1);
      check_eq($sformatf("arb_grant%0d", g), GNT1, exp_seq[g]);
      tick();
      SEQ_DONE = 1'b1;
      tick();
      SEQ_DONE = 1'b0;
      check_eq($sformatf("arb_gap%0d", g), 32'(GNT0 | GNT1), 0);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;

    // Urgent refresh overrides a held CPU request.
    do_reset(1'b1);
    REQ0   = 1'b1;
    waited = 0;
    while (REF_PENDING != 4'd4 && waited < 200) begin
      tick();
      waited++;
    end
    check_eq("urg_pend_climb", REF_PENDING, 4);
    check_eq("urg_still_busy", GNT0, 1);
    SEQ_DONE = 1'b1;
    tick();
    SEQ_DONE = 1'b0;
    check_eq("urg_idle_gnt0", GNT0, 0);
    tick();
    check_eq("urg_sel_refresh", SEQ_SEL, 2);
    check_eq("urg_start", SEQ_START, 1);
    check_eq("urg_no_gnt0", GNT0, 0);
    tick();
    check_eq("urg_pend_dec", REF_PENDING, 3);
    REQ0 = 1'b0;

    // Refresh start coinciding with a timer tick (edge 60), then saturation.
    do_reset(1'b1);
    REQ0 = 1'b1;
    while (cyc < 57) tick();
    SEQ_DONE = 1'b1;
    REQ0     = 1'b0;
    tick();
    SEQ_DONE = 1'b0;
    tick();
    check_eq("coin_sel", SEQ_SEL, 2);
    check_eq("coin_start", SEQ_START, 1);
    check_eq("coin_pend_before", REF_PENDING, 2);
    tick();
    check_eq("coin_pend_after", REF_PENDING, 2);
    repeat (240) tick();
    check_eq("sat_pend", REF_PENDING, 8);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 780, meaning CLK cycles between refresh ticks.
REQ-002 SHALL have parameter URGENT_LEVEL, default 4, meaning the pending-refresh count at which refresh beats all requesters.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port INIT_DONE, input, 1, high once SDRAM initialisation is complete.
REQ-006 SHALL have port REQ0, input, 1, CPU port level request.
REQ-007 SHALL have port REQ1, input, 1, secondary (DMA/video) port level request.
REQ-008 SHALL have port SEQ_DONE, input, 1, one-cycle pulse from the access sequencer at cycle end.
REQ-009 SHALL have port GNT0, output, 1, CPU port owns the sequencer.
REQ-010 SHALL have port GNT1, output, 1, secondary port owns the sequencer.
REQ-011 SHALL have port SEQ_START, output, 1, one-cycle start pulse to the sequencer.
REQ-012 SHALL have port SEQ_SEL, output, 2, 00 = port 0, 01 = port 1, 10 = refresh, 11 = none.
REQ-013 SHALL have port REF_PENDING, output, 4, count of owed refreshes.

Function
REQ-014 SHALL implement states IDLE, START and BUSY.
REQ-015 IDLE with INIT_DONE=0 SHALL issue no grant; the refresh timer is held at reload and REF_PENDING at 0.
REQ-016 IDLE SHALL select a winner from requests present at the clock edge and enter START on the next edge, giving 1-cycle REQ-to-GNT latency.
REQ-017 Selection order SHALL be: refresh if REF_PENDING >= URGENT_LEVEL; otherwise ports per REQ-031; otherwise refresh if REF_PENDING > 0; otherwise stay IDLE with SEQ_SEL=11.
REQ-018 START SHALL last exactly one cycle with SEQ_START=1, then enter BUSY.
REQ-019 The GNTx of the winner SHALL be high from START through the cycle SEQ_DONE is sampled; a refresh winner drives no GNT.
REQ-020 BUSY SHALL exit to IDLE on SEQ_DONE=1; GNT and SEQ_SEL return to 0 and 11 on that edge, giving at least one IDLE cycle between grants.
REQ-021 A request withdrawn during START or BUSY SHALL NOT truncate the grant; SEQ_DONE alone ends it.
REQ-022 SEQ_DONE sampled in IDLE or START SHALL be ignored.
REQ-023 The refresh timer SHALL count down from REFRESH_PERIOD-1; at 0 it reloads and REF_PENDING increments, saturating at 8.
REQ-024 REF_PENDING SHALL decrement on the SEQ_START cycle when SEQ_SEL=10.
REQ-025 A tick coinciding with that decrement SHALL leave REF_PENDING unchanged.
REQ-026 The timer SHALL run regardless of arbiter state.
REQ-027 GNT0 and GNT1 SHALL never be high together, and no grant SHALL be active when SEQ_SEL=10.

Reset
REQ-028 RESET high SHALL immediately force IDLE, GNT0=GNT1=0, SEQ_START=0, SEQ_SEL=11, REF_PENDING=0, timer=REFRESH_PERIOD-1 and last-grant=port 1.
REQ-029 Reset mid-BUSY SHALL abandon the cycle with no further SEQ_START until a new selection.
REQ-030 After RESET falls, the first selection SHALL occur on the second rising edge at earliest.

Configuration
REQ-031 With macro SDRAM_ARB_ROUND_ROBIN_EN defined, simultaneous REQ0 and REQ1 SHALL be granted to the port not granted last; otherwise REQ0 always beats REQ1. A lone requester wins in both builds.

Structure
REQ-032 Package sdram_arb_pkg SHALL hold the SEQ_SEL encodings, the state encodings and the pending saturation constant 8.
REQ-033 The refresh timer and pending counter SHALL be sub-module sdram_refresh_timer; arbitration and the FSM stay in sdram_arbiter.

Verification
REQ-034 INIT_DONE=0, REQ0=1 for 2000 cycles -> no GNT or SEQ_START; REF_PENDING=0.
REQ-035 INIT_DONE=1, REQ0 pulsed, SEQ_DONE 5 cycles after START -> GNT0 one edge after REQ0, SEQ_START=1 for 1 cycle, GNT0 drops the edge after SEQ_DONE.
REQ-036 REQ0=REQ1=1 for 4 grants -> fixed build gives 0,0,0,0; SDRAM_ARB_ROUND_ROBIN_EN build gives 0,1,0,1.
REQ-037 REQ0 held, sequencer never idle-free, REFRESH_PERIOD=20, URGENT_LEVEL=4 -> REF_PENDING climbs to 4, the next selection is SEQ_SEL=10, and REF_PENDING becomes 3.
REQ-038 Timer tick in the same cycle as a refresh SEQ_START with REF_PENDING=2 -> REF_PENDING stays 2; 12 ticks with no service -> REF_PENDING saturates at 8.
REQ-039 RESET asserted in BUSY with GNT1=1 -> GNT1=0 and SEQ_SEL=11 without waiting for a clock; REF_PENDING=0.
